systolic_array_sequencer: RTL and testbench
===========================================

SYSTOLIC_ARRAY_SEQUENCER -- requirements
Module: systolic_array_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, operand width of each x and w element.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 w_load  input  1  weight-load strobe.
REQ-005 w_in  input  3*WIDTH  weights {w3,w2,w1}, w1 in LSBs, signed.
REQ-006 row_valid, row_ready  input, output  1 each  row handshake.
REQ-007 row_data  input  3*WIDTH  row {x3,x2,x1}, x1 in LSBs, signed.
REQ-008 row_last  input  1  marks final row of a job.
REQ-009 pe_w1, pe_w2, pe_w3  output  WIDTH each  weights to PE1..PE3.
REQ-010 pe_x1, pe_x2, pe_x3  output  WIDTH each  skewed operands to PE1..PE3.
REQ-011 pe_en1, pe_en2, pe_en3  output  1 each  PE capture enables; replace the separate per-PE clocks.
REQ-012 pe_yin  output  2*WIDTH  partial-sum seed; constant zero.
REQ-013 pe_y  input  2*WIDTH  array result, signed.
REQ-014 res_valid, res_ready  output, input  1 each  result handshake.
REQ-015 res_data  output  2*WIDTH  captured result; res_last  output  1  final-result marker.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN.
REQ-018 IDLE: w_load=1 loads w_in into pe_w1..3 at the next edge; row_ready=0 that cycle. When w_load=1 and row_valid=1 in the same cycle, the weight load wins.
REQ-019 w_load is ignored in RUN and DRAIN; pe_w1..3 hold.
REQ-020 IDLE and RUN: row_ready = ~w_load_effective & ~stall. DRAIN: row_ready=0.
REQ-021 stall = res_valid & ~res_ready; during stall, all skew registers, enables and result capture freeze.
REQ-022 Row accepted at edge t (row_valid & row_ready): pe_x1=x1 with pe_en1=1 in cycle t+1; pe_x2=x2 with pe_en2=1 in t+2; pe_x3=x3 with pe_en3=1 in t+3 (cycles counted without stall).
REQ-023 Result capture: res_data <= pe_y at the edge ending cycle t+3; res_valid=1 from t+4. Fixed latency 4 unstalled cycles from acceptance to res_valid.
REQ-024 Throughput one row per cycle; back-to-back rows overlap in the skew pipeline, with each PE's enable and operand tagged to its own row.
REQ-025 pe_enK=0 in any cycle with no valid row in stage K; pe_xK then holds its last value.
REQ-026 Acceptance of a row in IDLE moves to RUN; acceptance with row_last=1 moves to DRAIN (from IDLE or RUN). The single-row job IDLE->DRAIN is legal.
REQ-027 row_last propagates with its row; res_last=1 accompanies that row's result.
REQ-028 DRAIN -> IDLE on the edge where the result with res_last is accepted (res_valid & res_ready).
REQ-029 res_valid clears on acceptance unless a new result is captured at the same edge, in which case it stays 1 with new res_data.
REQ-030 Arithmetic performed by the array: pe_y = x1*w1 + x2*w2 + x3*w3 (signed, 2*WIDTH, two's-complement wrap); the sequencer never modifies pe_y.

Reset
REQ-031 rst_n=0 forces asynchronously: state=IDLE, pe_w*=0, pe_x*=0, pe_en*=0, pe_yin=0, res_valid=0, res_data=0, res_last=0, busy=0, all skew valid bits=0.
REQ-032 Reset mid-job discards all in-flight rows and results; no result is emitted after deassertion.
REQ-033 row_ready=0 while rst_n=0.

Verification
REQ-034 Weight load w_in={2,8,17}, then row {29,28,44} with row_last=1, res_ready=1 -> pe_en1/2/3 pulse in consecutive cycles t+1..t+3; res_data=1030 and res_last=1 at t+4; busy falls the cycle after acceptance.
REQ-035 Two back-to-back rows {29,28,44} then {21,16,14} (last) -> results 1030 then 408 on consecutive cycles; res_last only on 408.
REQ-036 Same as REQ-035 with res_ready=0 for 3 cycles after the first res_valid -> res_data holds at 1030, enables frozen, row_ready=0; then 408 follows; no loss or duplication.
REQ-037 w_load=1 during RUN with w_in={1,1,1} -> pe_w unchanged; results still computed with the old weights.
REQ-038 Same cycle w_load=1 and row_valid=1 in IDLE -> weights load, row not accepted; row accepted the following cycle.
REQ-039 rst_n pulsed low at t+2 of a job -> all outputs at reset values immediately; res_valid stays 0 afterwards; state=IDLE.

Source files
------------

// File: rtl/systolic_array_sequencer.sv
// rtl/systolic_array_sequencer.sv - feeds skewed rows and weights into a 3-PE systolic array
// and collects one result per row through a valid/ready handshake.
module systolic_array_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_load,
  input  logic [3*WIDTH-1:0]   w_in,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [3*WIDTH-1:0]   row_data,
  input  logic                 row_last,
  output logic [WIDTH-1:0]     pe_w1,
  output logic [WIDTH-1:0]     pe_w2,
  output logic [WIDTH-1:0]     pe_w3,
  output logic [WIDTH-1:0]     pe_x1,
  output logic [WIDTH-1:0]     pe_x2,
  output logic [WIDTH-1:0]     pe_x3,
  output logic                 pe_en1,
  output logic                 pe_en2,
  output logic                 pe_en3,
  output logic [2*WIDTH-1:0]   pe_yin,
  input  logic [2*WIDTH-1:0]   pe_y,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_last,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nx;
  logic              stall, accept, w_load_eff;
  logic              v1, v2, v3;
  logic              last1, last2, last3;
  logic [WIDTH-1:0]  x2_d1, x3_d1, x3_d2;

  assign stall  = res_valid & ~res_ready;
  assign accept = row_valid & row_ready;
  assign pe_yin = '0;

  // Enables are gated by stall so the array never re-captures while the pipeline is frozen.
  assign pe_en1 = v1 & ~stall;
  assign pe_en2 = v2 & ~stall;
  assign pe_en3 = v3 & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    row_ready  = 1'b0;
    w_load_eff = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        w_load_eff = w_load;
        row_ready  = rst_n & ~w_load & ~stall;
        if (row_valid && row_ready) state_nx = row_last ? DRAIN : RUN;
      end
      RUN: begin
        row_ready = rst_n & ~stall;
        if (row_valid && row_ready && row_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (res_valid && res_ready && res_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_w1 <= '0;
      pe_w2 <= '0;
      pe_w3 <= '0;
    end else if (w_load_eff) begin
      {pe_w3, pe_w2, pe_w1} <= w_in;
    end
  end

  // Each stage carries the remaining operands of its own row, so overlapping rows stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      last1     <= 1'b0;
      last2     <= 1'b0;
      last3     <= 1'b0;
      pe_x1     <= '0;
      pe_x2     <= '0;
      pe_x3     <= '0;
      x2_d1     <= '0;
      x3_d1     <= '0;
      x3_d2     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) begin
        pe_x1 <= row_data[WIDTH-1:0];
        x2_d1 <= row_data[2*WIDTH-1:WIDTH];
        x3_d1 <= row_data[3*WIDTH-1:2*WIDTH];
        last1 <= row_last;
      end
      v2 <= v1;
      if (v1) begin
        pe_x2 <= x2_d1;
        x3_d2 <= x3_d1;
        last2 <= last1;
      end
      v3 <= v2;
      if (v2) begin
        pe_x3 <= x3_d2;
        last3 <= last2;
      end
      res_valid <= v3;
      if (v3) begin
        res_data <= pe_y;
        res_last <= last3;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// tb/tb_systolic_array_sequencer.sv - scoreboard bench with a behavioural PE array and dot-product model.
module tb_systolic_array_sequencer;

  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            w_load;
  logic [3*W-1:0]  w_in;
  logic            row_valid, row_ready;
  logic [3*W-1:0]  row_data;
  logic            row_last;
  logic [W-1:0]    pe_w1, pe_w2, pe_w3, pe_x1, pe_x2, pe_x3;
  logic            pe_en1, pe_en2, pe_en3;
  logic [2*W-1:0]  pe_yin, pe_y;
  logic            res_valid, res_ready, res_last, busy;
  logic [2*W-1:0]  res_data;

  systolic_array_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data), .row_last(row_last),
    .pe_w1(pe_w1), .pe_w2(pe_w2), .pe_w3(pe_w3),
    .pe_x1(pe_x1), .pe_x2(pe_x2), .pe_x3(pe_x3),
    .pe_en1(pe_en1), .pe_en2(pe_en2), .pe_en3(pe_en3),
    .pe_yin(pe_yin), .pe_y(pe_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural systolic array: two partial-sum registers, last PE combinational into pe_y.
  logic signed [2*W-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (pe_en1) p1 <= $signed(pe_yin) + $signed(pe_x1) * $signed(pe_w1);
    if (pe_en2) p2 <= p1 + $signed(pe_x2) * $signed(pe_w2);
  end
  assign pe_y = p2 + $signed(pe_x3) * $signed(pe_w3);

  typedef struct { logic [2*W-1:0] data; logic last; } exp_t;
  exp_t            exp_q[$];
  logic [3*W-1:0]  model_w = '0;
  bit              model_busy = 0;
  int              n_checks = 0, n_fail = 0;
  bit              rand_ready = 0;

  localparam logic [3*W-1:0] ROW_A = {8'd29, 8'd28, 8'd44};
  localparam logic [3*W-1:0] ROW_B = {8'd21, 8'd16, 8'd14};
  localparam logic [3*W-1:0] WTS   = {8'd2, 8'd8, 8'd17};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] dot(input logic [3*W-1:0] w, input logic [3*W-1:0] x);
    int s = 0;
    for (int k = 0; k < 3; k++)
      s += int'($signed(w[W*k +: W])) * int'($signed(x[W*k +: W]));
    return s[2*W-1:0];
  endfunction

  // Monitor: track the reference model and score every accepted result.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_busy = 0;
      model_w    = '0;
    end else begin
      if (w_load && !model_busy) model_w = w_in;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_res_data", res_data, e.data);
          chk("sb_res_last", res_last, e.last);
          if (e.last) model_busy = 0;
        end
      end
      if (row_valid && row_ready) begin
        exp_q.push_back('{data: dot(model_w, row_data), last: row_last});
        model_busy = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_row(input logic [3*W-1:0] d, input logic l);
    bit ok = 0;
    row_data  = d;
    row_last  = l;
    row_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (row_ready) begin ok = 1; break; end
      tick();
    end
    chk("row_accept_timeout", ok, 1);
    tick();
    row_valid = 1'b0;
  endtask

  task automatic wait_res();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; break; end
    end
    chk("res_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
      tick();
    end
    chk("idle_timeout", ok, 1);
    tick();
  endtask

  task automatic load_w(input logic [3*W-1:0] w);
    w_load = 1'b1;
    w_in   = w;
    tick();
    w_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; w_load = 0; w_in = '0; row_valid = 0; row_data = '0; row_last = 0; res_ready = 1;
    #3;
    chk("rst_row_ready", row_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_pe_en", {pe_en3, pe_en2, pe_en1}, 0);
    chk("rst_pe_yin", pe_yin, 0);
    chk("rst_pe_w", {pe_w3, pe_w2, pe_w1}, 0);
    chk("rst_pe_x", {pe_x3, pe_x2, pe_x1}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // Single-row job: skew timing, latency and busy fall.
    w_load = 1; w_in = WTS; row_valid = 1; row_data = ROW_A; row_last = 1;
    @(negedge clk);
    chk("wload_blocks_row", row_ready, 0);
    tick();
    w_load = 0;
    @(negedge clk);
    chk("w_loaded_w1", pe_w1, 17);
    chk("w_loaded_w3", pe_w3, 2);
    chk("row_ready_after_load", row_ready, 1);
    tick();
    row_valid = 0;
    @(negedge clk);
    chk("t1_en", {pe_en3, pe_en2, pe_en1}, 3'b001);
    chk("t1_x1", pe_x1, 44);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t2_en", {pe_en3, pe_en2, pe_en1}, 3'b010);
    chk("t2_x2", pe_x2, 28);
    @(negedge clk);
    chk("t3_en", {pe_en3, pe_en2, pe_en1}, 3'b100);
    chk("t3_x3", pe_x3, 29);
    @(negedge clk);
    chk("t4_res_valid", res_valid, 1);
    chk("t4_res_data", res_data, 1030);
    chk("t4_res_last", res_last, 1);
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_res_valid", res_valid, 0);
    tick();

    // Back-to-back rows.
    send_row(ROW_A, 0);
    send_row(ROW_B, 1);
    wait_res();
    chk("b2b_first", res_data, 1030);
    chk("b2b_first_last", res_last, 0);
    @(negedge clk);
    chk("b2b_second_valid", res_valid, 1);
    chk("b2b_second", res_data, 408);
    chk("b2b_second_last", res_last, 1);
    wait_idle();

    // Backpressure on the first result.
    res_ready = 0;
    send_row(ROW_A, 0);
    send_row(ROW_B, 1);
    wait_res();
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold_data", res_data, 1030);
      chk("stall_row_ready", row_ready, 0);
      chk("stall_en", {pe_en3, pe_en2, pe_en1}, 0);
      if (i < 2) @(negedge clk);
    end
    tick();
    res_ready = 1;
    @(negedge clk);
    chk("stall_release_first", res_data, 1030);
    @(negedge clk);
    chk("stall_second_valid", res_valid, 1);
    chk("stall_second", res_data, 408);
    wait_idle();

    // Weight load during RUN is ignored.
    send_row(ROW_A, 0);
    w_load = 1; w_in = {8'd1, 8'd1, 8'd1};
    send_row(ROW_B, 1);
    w_load = 0;
    wait_res();
    chk("run_wload_res", res_data, 1030);
    chk("run_wload_w1", pe_w1, 17);
    chk("run_wload_w2", pe_w2, 8);
    wait_idle();

    // Weight load and row in the same IDLE cycle.
    w_load = 1; w_in = {8'd3, 8'hFE, 8'd5}; row_data = ROW_A; row_last = 1; row_valid = 1;
    @(negedge clk);
    chk("same_cycle_ready", row_ready, 0);
    tick();
    w_load = 0;
    @(negedge clk);
    chk("next_cycle_ready", row_ready, 1);
    chk("same_cycle_w1", pe_w1, 5);
    tick();
    row_valid = 0;
    wait_res();
    chk("same_cycle_res", res_data, 251);
    wait_idle();

    // Reset in the middle of a job.
    load_w(WTS);
    send_row(ROW_A, 1);
    @(negedge clk);
    tick();
    rst_n = 0;
    #1;
    chk("midrst_en", {pe_en3, pe_en2, pe_en1}, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_w", {pe_w3, pe_w2, pe_w1}, 0);
    chk("midrst_x", {pe_x3, pe_x2, pe_x1}, 0);
    chk("midrst_row_ready", row_ready, 0);
    chk("midrst_res_data", res_data, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("postrst_res_valid", res_valid, 0);
    end
    chk("postrst_busy", busy, 0);
    tick();

    // Randomized jobs with random backpressure and row gaps.
    rand_ready = 1;
    for (int j = 0; j < 15; j++) begin
      int n;
      load_w($urandom);
      n = $urandom_range(1, 6);
      for (int r = 0; r < n; r++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_row($urandom, (r == n - 1));
      end
      wait_idle();
    end
    rand_ready = 0;
    res_ready  = 1;
    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
